// File: rtl/branch_cmp_arbiter_if.sv
// Bundle between two branch requesters, the shared external comparator and
// the resolved-branch consumer.
//   req0_* / req1_* : request channels (valid/ready handshake, branch fields)
//   cmp_op/a/b, cmp_f : drive to / result from the shared comparator
//   resp_*          : registered resolved-branch response (valid/ready)
// Modports:
//   slave  : the arbiter (takes requests, drives comparator and response)
//   master : the surrounding pipeline plus the comparator itself
interface branch_cmp_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_funct3;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req0_pc;
  logic [WIDTH-1:0] req0_imm;
  logic             req0_pred;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_funct3;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [WIDTH-1:0] req1_pc;
  logic [WIDTH-1:0] req1_imm;
  logic             req1_pred;
  logic [TAG_W-1:0] req1_tag;

  logic [2:0]       cmp_op;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             cmp_f;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_taken;
  logic [WIDTH-1:0] resp_next_pc;
  logic             resp_mispred;
  logic             resp_illegal;

  modport slave (
    input  req0_valid, req0_funct3, req0_a, req0_b, req0_pc, req0_imm, req0_pred, req0_tag,
    output req0_ready,
    input  req1_valid, req1_funct3, req1_a, req1_b, req1_pc, req1_imm, req1_pred, req1_tag,
    output req1_ready,
    output cmp_op, cmp_a, cmp_b,
    input  cmp_f,
    output resp_valid, resp_id, resp_tag, resp_taken, resp_next_pc, resp_mispred, resp_illegal,
    input  resp_ready
  );

  modport master (
    output req0_valid, req0_funct3, req0_a, req0_b, req0_pc, req0_imm, req0_pred, req0_tag,
    input  req0_ready,
    output req1_valid, req1_funct3, req1_a, req1_b, req1_pc, req1_imm, req1_pred, req1_tag,
    input  req1_ready,
    input  cmp_op, cmp_a, cmp_b,
    output cmp_f,
    input  resp_valid, resp_id, resp_tag, resp_taken, resp_next_pc, resp_mispred, resp_illegal,
    output resp_ready
  );
endinterface

// File: rtl/branch_cmp_arbiter.sv
// Shares one external branch comparator between two requesters. Each cycle
// at most one request is granted (round-robin on ties), its operands are
// steered to the comparator, and the resolved branch (outcome, next PC,
// mispredict, illegal funct3) is captured into a single response register.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   flush : drops the held response and blocks acceptance this cycle
//   bus   : request, comparator and response signals (slave side)
module branch_cmp_arbiter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  branch_cmp_arbiter_if.slave   bus
);

  logic             rr_ptr;      // requester that wins the next tie
  logic             grant;
  logic             slot_free;
  logic             can_acc;
  logic             accept;

  logic [2:0]       sel_funct3;
  logic [WIDTH-1:0] sel_pc;
  logic [WIDTH-1:0] sel_imm;
  logic             sel_pred;
  logic [TAG_W-1:0] sel_tag;
  logic             sel_illegal;
  logic             sel_taken;
  logic [WIDTH-1:0] sel_next_pc;

  logic             resp_valid_q;
  logic             resp_id_q;
  logic [TAG_W-1:0] resp_tag_q;
  logic             resp_taken_q;
  logic [WIDTH-1:0] resp_next_pc_q;
  logic             resp_mispred_q;
  logic             resp_illegal_q;

  // Grant: a lone valid requester wins; on a tie rr_ptr decides. With no
  // request the grant rests on req0 so the comparator mux has a defined input.
  always_comb begin
    // NOTE: assign a default before any branch so no path infers a latch.
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant = rr_ptr;
    else if (bus.req1_valid)              grant = 1'b1;
  end

  // The response register can take a new entry when empty or being drained
  // this same edge, which gives back-to-back responses with no bubble.
  assign slot_free = !resp_valid_q || bus.resp_ready;
  assign can_acc   = slot_free && !flush && !rst;

  assign bus.req0_ready = can_acc && bus.req0_valid && !grant;
  assign bus.req1_ready = can_acc && bus.req1_valid &&  grant;
  assign accept         = bus.req0_ready || bus.req1_ready;

  always_comb begin
    sel_funct3 = bus.req0_funct3;
    bus.cmp_a  = bus.req0_a;
    bus.cmp_b  = bus.req0_b;
    sel_pc     = bus.req0_pc;
    sel_imm    = bus.req0_imm;
    sel_pred   = bus.req0_pred;
    sel_tag    = bus.req0_tag;
    if (grant) begin
      sel_funct3 = bus.req1_funct3;
      bus.cmp_a  = bus.req1_a;
      bus.cmp_b  = bus.req1_b;
      sel_pc     = bus.req1_pc;
      sel_imm    = bus.req1_imm;
      sel_pred   = bus.req1_pred;
      sel_tag    = bus.req1_tag;
    end
  end

  assign bus.cmp_op = sel_funct3;

  // funct3 010/011 are not branch encodings; such a request resolves as
  // not-taken and falls through, and whatever the comparator says is ignored.
  assign sel_illegal = (sel_funct3[2:1] == 2'b01);
  assign sel_taken   = !sel_illegal && bus.cmp_f;
  // Both sums wrap modulo 2^WIDTH by truncation.
  assign sel_next_pc = sel_taken ? (sel_pc + sel_imm) : (sel_pc + WIDTH'(4));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      resp_valid_q   <= 1'b0;
      resp_id_q      <= 1'b0;
      resp_tag_q     <= '0;
      resp_taken_q   <= 1'b0;
      resp_next_pc_q <= '0;
      resp_mispred_q <= 1'b0;
      resp_illegal_q <= 1'b0;
      rr_ptr         <= 1'b0;
    end else if (flush) begin
      // can_acc is low here, so no accept competes with the kill.
      resp_valid_q <= 1'b0;
    end else if (accept) begin
      resp_valid_q   <= 1'b1;
      resp_id_q      <= grant;
      resp_tag_q     <= sel_tag;
      resp_taken_q   <= sel_taken;
      resp_next_pc_q <= sel_next_pc;
      resp_mispred_q <= sel_taken != sel_pred;
      resp_illegal_q <= sel_illegal;
      rr_ptr         <= ~grant;
    end else if (bus.resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_id      = resp_id_q;
  assign bus.resp_tag     = resp_tag_q;
  assign bus.resp_taken   = resp_taken_q;
  assign bus.resp_next_pc = resp_next_pc_q;
  assign bus.resp_mispred = resp_mispred_q;
  assign bus.resp_illegal = resp_illegal_q;

endmodule
